ram_write_key_ctrl: RTL and testbench

//  Upstream write stage for the 32x4 dual-port RAM show-time board path.

---
 rtl/ram_write_key_ctrl_pkg.sv | 18 +
 rtl/ram_write_key_ctrl_key_debounce.sv | 68 ++++++
 rtl/ram_write_key_ctrl.sv | 103 ++++++++++
 tb/tb_ram_write_key_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ram_write_key_ctrl_pkg.sv
// Shared definitions for the RAM write-key path: width defaults,
// write FSM state encodings and the debounce length helper.
package ram_write_key_ctrl_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRB = 2'd1,
        HOLD = 2'd2
    } wr_state_e;

    function automatic int db_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/ram_write_key_ctrl_key_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low key.
// Emits the debounced level and registered 1-cycle press/release pulses.
module ram_write_key_ctrl_key_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic stable,
    output logic press,
    output logic rel
);

    localparam int CNT_W = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Edge pulses come one cycle after the level settles.
        prev_d  = stable_q;
        press_d = prev_q & ~stable_q;
        rel_d   = ~prev_q & stable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            prev_q   <= 1'b1;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;
    assign rel    = rel_q;

endmodule

// File: rtl/ram_write_key_ctrl.sv
// Pushbutton-driven RAM write stage: one captured write strobe per
// clean key press, blocked until the key release has been debounced.
module ram_write_key_ctrl
    import ram_write_key_ctrl_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              key_n,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [7:0]        write_count
);

    localparam int DB_CYC = db_cycles(CLK_HZ, DEBOUNCE_MS);

    logic key_stable;
    logic key_press;
    logic key_rel;

    ram_write_key_ctrl_key_debounce #(
        .DB_CYC (DB_CYC)
    ) u_db (
        .clk    (CLOCK_50),
        .reset  (reset),
        .key_n  (key_n),
        .stable (key_stable),
        .press  (key_press),
        .rel    (key_rel)
    );

    wr_state_e         state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic [7:0]        count_q, count_d;

    always_comb begin
        state_d = state_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (key_press) begin
                    state_d = STRB;
                    addr_d  = sw_addr;
                    data_d  = sw_data;
                    wr_en_d = 1'b1;
                    busy_d  = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            STRB: state_d = HOLD;
            HOLD: begin
                if (key_rel && key_stable) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign busy        = busy_q;
    assign write_count = count_q;

endmodule

// File: tb/tb_ram_write_key_ctrl.sv
// Directed bench for ram_write_key_ctrl with a 4-cycle debounce window.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_ram_write_key_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       key_n;
    logic [4:0] sw_addr;
    logic [3:0] sw_data;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic       busy;
    logic [7:0] write_count;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int p0;

    ram_write_key_ctrl #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .ADDR_W      (5),
        .DATA_W      (4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key_n       (key_n),
        .sw_addr     (sw_addr),
        .sw_data     (sw_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .write_count (write_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (wr_en === 1'b1) pulses <= pulses + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        key_n   = 1'b1;
        sw_addr = 5'h00;
        sw_data = 4'h0;
        tick(3);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(write_count), 32'd0);
        reset = 1'b0;
        tick(2);

        // First press: strobe exactly at edge 7 after key is sampled low
        sw_addr = 5'h13;
        sw_data = 4'hA;
        key_n   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk($sformatf("p1_wr_en_e%0d", i), 32'(wr_en), 32'(i == 7));
            if (i == 7) begin
                chk("p1_addr", 32'(wr_addr), 32'h13);
                chk("p1_data", 32'(wr_data), 32'hA);
                chk("p1_count", 32'(write_count), 32'd1);
                chk("p1_busy", 32'(busy), 32'd1);
            end
        end
        key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk($sformatf("p1_rel_busy_e%0d", i), 32'(busy), 32'(i < 7));
        end

        // Bounce: low pulses of 1..3 cycles never reach the window
        p0 = pulses;
        for (int k = 0; k < 3; k++) begin
            for (int len = 1; len <= 3; len++) begin
                key_n = 1'b0;
                tick(len);
                key_n = 1'b1;
                tick(1);
            end
        end
        tick(10);
        chk("bounce_pulses", 32'(pulses - p0), 32'd0);
        chk("bounce_busy", 32'(busy), 32'd0);
        chk("bounce_count", 32'(write_count), 32'd1);

        // Long hold with data change mid-hold: one write, old data kept
        p0    = pulses;
        key_n = 1'b0;
        tick(50);
        sw_data = 4'h5;
        tick(50);
        chk("hold_pulses", 32'(pulses - p0), 32'd1);
        chk("hold_data", 32'(wr_data), 32'hA);
        chk("hold_count", 32'(write_count), 32'd2);
        chk("hold_busy", 32'(busy), 32'd1);
        key_n = 1'b1;
        tick(12);
        chk("hold_rel_busy", 32'(busy), 32'd0);
        chk("idle_data_held", 32'(wr_data), 32'hA);
        key_n = 1'b0;
        tick(10);
        chk("p2_pulses", 32'(pulses - p0), 32'd2);
        chk("p2_data", 32'(wr_data), 32'h5);
        chk("p2_addr", 32'(wr_addr), 32'h13);
        chk("p2_count", 32'(write_count), 32'd3);

        // Reset during HOLD with the key still low
        reset = 1'b1;
        tick(1);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_data", 32'(wr_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(write_count), 32'd0);
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk($sformatf("rr_wr_en_e%0d", i), 32'(wr_en), 32'(i == 7));
            if (i == 7) begin
                chk("rr_count", 32'(write_count), 32'd1);
                chk("rr_data", 32'(wr_data), 32'h5);
            end
        end
        key_n = 1'b1;
        tick(12);

        // 256 clean presses wrap the counter back to zero
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        p0 = pulses;
        for (int k = 0; k < 256; k++) begin
            key_n = 1'b0;
            tick(10);
            if (k == 0 || k == 127 || k == 254) begin
                chk($sformatf("wrap_count_k%0d", k), 32'(write_count),
                    32'(k + 1));
            end
            key_n = 1'b1;
            tick(10);
        end
        chk("wrap_count_final", 32'(write_count), 32'd0);
        chk("wrap_pulses", 32'(pulses - p0), 32'd256);
        chk("wrap_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
